// File: rtl/spi_mode_arbiter.sv
// Round-robin front end for a shared SPI master: latches the winner's mode/byte,
// holds them through a setup window, pulses spi_start and watches spi_cs for completion.
module spi_mode_arbiter #(
    parameter int NREQ       = 4,
    parameter int SETUP_CYC  = 2,
    parameter int CS_TIMEOUT = 8,
    parameter int GAP_CYC    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [2*NREQ-1:0]    req_mode,
    input  logic [8*NREQ-1:0]    req_data,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      done,
    output logic [NREQ-1:0]      err,
    output logic                 busy,
    output logic                 spi_start,
    output logic [1:0]           spi_mode,
    output logic [7:0]           spi_din,
    input  logic                 spi_cs
);

    localparam int MAXC = (SETUP_CYC > CS_TIMEOUT)
                        ? ((SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC)
                        : ((CS_TIMEOUT > GAP_CYC) ? CS_TIMEOUT : GAP_CYC);
    localparam int CW = $clog2(MAXC) + 1;
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYC - 1);
    // The LAUNCH cycle is the first of the CS_TIMEOUT window, and WAIT_LOW
    // entry clears the counter, hence the -2.
    localparam logic [CW-1:0] TO_LAST    = CW'(CS_TIMEOUT - 2);

    typedef enum logic [2:0] {IDLE, SETUP, LAUNCH, WAIT_LOW, WAIT_HIGH, GAP} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   last;

    logic [NREQ-1:0] sel_oh;
    logic [IW-1:0]   sel_idx;
    logic [1:0]      sel_mode;
    logic [7:0]      sel_data;

    // Pass 0 finds the lowest index at or below last (wrap-around candidates);
    // pass 1 overrides it with the lowest index above last, which has priority.
    always_comb begin
        sel_oh   = '0;
        sel_idx  = '0;
        sel_mode = '0;
        sel_data = '0;
        for (int p = 0; p < 2; p++) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                if (req[k] && ((IW'(k) > last) == (p == 1))) begin
                    sel_oh    = '0;
                    sel_oh[k] = 1'b1;
                    sel_idx   = IW'(k);
                    sel_mode  = req_mode[2*k +: 2];
                    sel_data  = req_data[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            last      <= IW'(NREQ - 1);
            grant     <= '0;
            done      <= '0;
            err       <= '0;
            busy      <= 1'b0;
            spi_start <= 1'b0;
            spi_mode  <= 2'b00;
            spi_din   <= 8'h00;
        end else begin
            spi_start <= 1'b0;
            done      <= '0;
            err       <= '0;
            cnt       <= cnt + 1'b1;
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        grant    <= sel_oh;
                        last     <= sel_idx;
                        busy     <= 1'b1;
                        spi_mode <= sel_mode;
                        spi_din  <= sel_data;
                        cnt      <= '0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        spi_start <= 1'b1;
                        cnt       <= '0;
                        state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    cnt   <= '0;
                    state <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    if (!spi_cs) begin
                        cnt   <= '0;
                        state <= WAIT_HIGH;
                    end else if (cnt == TO_LAST) begin
                        err   <= grant;
                        cnt   <= '0;
                        state <= GAP;
                    end
                end
                WAIT_HIGH: begin
                    if (spi_cs) begin
                        done  <= grant;
                        cnt   <= '0;
                        state <= GAP;
                    end
                end
                GAP: begin
                    // grant drops on the same edge that ends the done/err pulse
                    grant <= '0;
                    if (cnt == GAP_LAST) begin
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mode_arbiter.sv
// Directed bench for spi_mode_arbiter with a behavioural SPI master driving spi_cs.
module tb_spi_mode_arbiter;

    localparam int NREQ = 4, SETUP_CYC = 2, CS_TIMEOUT = 8, GAP_CYC = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NREQ-1:0] req = '0;
    logic [7:0]      req_mode = '0;
    logic [31:0]     req_data = '0;
    logic [NREQ-1:0] grant, done, err;
    logic            busy, spi_start;
    logic [1:0]      spi_mode;
    logic [7:0]      spi_din;
    logic            spi_cs = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    spi_mode_arbiter #(.NREQ(NREQ), .SETUP_CYC(SETUP_CYC), .CS_TIMEOUT(CS_TIMEOUT), .GAP_CYC(GAP_CYC)) dut (
        .clk(clk), .rst(rst), .req(req), .req_mode(req_mode), .req_data(req_data),
        .grant(grant), .done(done), .err(err), .busy(busy), .spi_start(spi_start),
        .spi_mode(spi_mode), .spi_din(spi_din), .spi_cs(spi_cs));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model master: cs falls m_dly cycles after spi_start, stays low m_len cycles.
    bit m_hang = 1'b0;
    int m_dly = 1, m_len = 4, m_ph = 0, m_cnt = 0;
    initial forever begin
        @(negedge clk);
        if (rst) begin
            spi_cs = 1'b1; m_ph = 0;
        end else begin
            case (m_ph)
                0: if (spi_start && !m_hang) begin m_ph = 1; m_cnt = m_dly; end
                1: begin m_cnt--; if (m_cnt == 0) begin spi_cs = 1'b0; m_ph = 2; m_cnt = m_len; end end
                default: begin m_cnt--; if (m_cnt == 0) begin spi_cs = 1'b1; m_ph = 0; end end
            endcase
        end
    end

    // Mode/byte must not move while a grant is held.
    logic [1:0] cap_m;
    logic [7:0] cap_d;
    bit hold = 1'b0, moved = 1'b0;
    initial forever begin
        @(negedge clk);
        if (grant != '0) begin
            if (!hold) begin hold = 1'b1; moved = 1'b0; cap_m = spi_mode; cap_d = spi_din; end
            else if (spi_mode !== cap_m || spi_din !== cap_d) moved = 1'b1;
        end else if (hold) begin
            hold = 1'b0;
            chk("mode_stable", 64'(moved), 64'd0);
        end
    end

    task automatic xfer(input logic [NREQ-1:0] r, input logic [7:0] md, input logic [31:0] dt,
                        input bit hang, input int len, input int idx, input bit e, input bit keep);
        int k;
        logic [1:0] em;
        logic [7:0] ed;
        em = md[2*idx +: 2];
        ed = dt[8*idx +: 8];
        @(negedge clk);
        req = r; req_mode = md; req_data = dt; m_hang = hang; m_len = len;
        @(posedge clk); #1;
        chk("grant", 64'(grant), 64'd1 << idx);
        chk("mode", 64'(spi_mode), 64'(em));
        chk("din", 64'(spi_din), 64'(ed));
        chk("busy", 64'(busy), 64'd1);
        k = 0;
        while (!spi_start && k < 20) begin @(posedge clk); #1; k++; end
        chk("setup_cyc", 64'(k), 64'(SETUP_CYC));
        chk("start_mode", 64'(spi_mode), 64'(em));
        @(posedge clk); #1;
        chk("start_pulse", 64'(spi_start), 64'd0);
        k = 1;
        while (!(done | err) && k < 200) begin @(posedge clk); #1; k++; end
        chk("xfer_cyc", 64'(k), e ? 64'(CS_TIMEOUT) : 64'(len + 2));
        chk("done", 64'(done), e ? 64'd0 : (64'd1 << idx));
        chk("err", 64'(err), e ? (64'd1 << idx) : 64'd0);
        @(negedge clk);
        if (!keep) req = '0;
        @(posedge clk); #1;
        chk("pulse_end", 64'(done | err), 64'd0);
        chk("grant_drop", 64'(grant), 64'd0);
        k = 1;
        while (busy && k < 50) begin @(posedge clk); #1; k++; end
        chk("gap_cyc", 64'(k), 64'(GAP_CYC));
    endtask

    task automatic finish_xfer();
        int k;
        k = 0;
        while (!(done | err) && k < 200) begin @(posedge clk); #1; k++; end
        chk("fin_pulse", 64'((done | err) != '0), 64'd1);
        @(negedge clk);
        req = '0;
        k = 0;
        while (busy && k < 50) begin @(posedge clk); #1; k++; end
        chk("fin_idle", 64'(busy), 64'd0);
    endtask

    typedef struct {
        logic [NREQ-1:0] r;
        logic [7:0]      md;
        logic [31:0]     dt;
        bit              hang;
        int              len;
        int              idx;
        bit              e;
    } vec_t;
    vec_t tbl[7];

    initial begin
        int k;
        tbl[0] = '{4'b0010, 8'h04, 32'h0000A500, 1'b0, 34, 1, 1'b0};
        tbl[1] = '{4'b1111, 8'hE4, 32'h44332211, 1'b0, 3,  2, 1'b0};
        tbl[2] = '{4'b0011, 8'hE4, 32'h44332211, 1'b1, 3,  0, 1'b1};
        tbl[3] = '{4'b1001, 8'hE4, 32'h44332211, 1'b0, 5,  3, 1'b0};
        tbl[4] = '{4'b0001, 8'h03, 32'h000000FF, 1'b0, 1,  0, 1'b0};
        tbl[5] = '{4'b1000, 8'h80, 32'h7E000000, 1'b1, 3,  3, 1'b1};
        tbl[6] = '{4'b0101, 8'h31, 32'h00C30018, 1'b0, 2,  0, 1'b0};

        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_done_err", 64'(done | err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_start", 64'(spi_start), 64'd0);
        chk("rst_mode_din", 64'({spi_mode, spi_din}), 64'd0);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 7; i++)
            xfer(tbl[i].r, tbl[i].md, tbl[i].dt, tbl[i].hang, tbl[i].len, tbl[i].idx, tbl[i].e, 1'b0);

        // All four requesting continuously from a fresh reset: 0,1,2,3,0
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        xfer(4'hF, 8'hE4, 32'h44332211, 1'b0, 2, 0, 1'b0, 1'b1);
        xfer(4'hF, 8'hE4, 32'h44332211, 1'b0, 3, 1, 1'b0, 1'b1);
        xfer(4'hF, 8'hE4, 32'h44332211, 1'b0, 2, 2, 1'b0, 1'b1);
        xfer(4'hF, 8'hE4, 32'h44332211, 1'b0, 4, 3, 1'b0, 1'b1);
        xfer(4'hF, 8'hE4, 32'h44332211, 1'b0, 2, 0, 1'b0, 1'b0);

        // Requester 0 changes data and drops req while its transfer is in WAIT_HIGH
        @(negedge clk);
        req = 4'b0001; req_mode = 8'h02; req_data = 32'h0000005A; m_hang = 1'b0; m_len = 10;
        @(posedge clk); #1;
        chk("mid_grant", 64'(grant), 64'h1);
        k = 0;
        while (!spi_start && k < 20) begin @(posedge clk); #1; k++; end
        repeat (4) @(negedge clk);
        req = 4'b0100; req_mode = 8'h11; req_data = 32'h00EE00C3;
        @(posedge clk); #1;
        chk("mid_din", 64'(spi_din), 64'h5A);
        chk("mid_mode", 64'(spi_mode), 64'h2);
        k = 0;
        while (!(done | err) && k < 100) begin @(posedge clk); #1; k++; end
        chk("mid_done", 64'(done), 64'h1);
        k = 0;
        while (busy && k < 50) begin @(posedge clk); #1; k++; end
        @(posedge clk); #1;
        chk("mid_next_grant", 64'(grant), 64'h4);
        chk("mid_next_din", 64'(spi_din), 64'hEE);
        finish_xfer();

        // Asynchronous reset in WAIT_HIGH, then arbitration restarts at requester 0
        @(negedge clk);
        req = 4'b0010; req_mode = 8'h04; req_data = 32'h0000A500; m_len = 34;
        k = 0;
        while (!spi_start && k < 20) begin @(posedge clk); #1; k++; end
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_grant", 64'(grant), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done_err", 64'(done | err), 64'd0);
        chk("arst_mode_din", 64'({spi_mode, spi_din}), 64'd0);
        @(negedge clk);
        req = 4'b1001; req_mode = 8'h00; m_len = 3;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("arst_first_grant", 64'(grant), 64'h1);
        finish_xfer();

        // Random traffic with inputs scrambled mid-transfer
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            req = 4'($urandom_range(1, 15));
            req_mode = 8'($urandom);
            req_data = $urandom;
            m_hang = ($urandom_range(0, 15) == 0);
            m_len = $urandom_range(1, 4);
            k = 0;
            while (!(done | err) && k < 100) begin
                @(negedge clk);
                if (grant != '0) begin req_mode = 8'($urandom); req_data = $urandom; end
                k++;
            end
            chk("rnd_bound", 64'(k < 100), 64'd1);
            chk("rnd_owner", 64'(done | err), 64'(grant));
            req = '0;
            k = 0;
            while (busy && k < 50) begin @(negedge clk); k++; end
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_mode_arbiter.md
# spi_mode_arbiter

Round-robin arbiter and sequencer placed in front of the SPI mode-capable master. It shares one master among NREQ requesters, each supplying its own 2-bit SPI mode {cpol,cphas} and 8-bit payload. It stabilises the mode before launch, issues the one-cycle start pulse, and tracks the master's chip-select to detect completion or a stalled launch. It returns a per-requester done or error pulse.

## Interface
- NREQ, 4: number of requesters (2..8).
- SETUP_CYC, 2: cycles spi_mode/spi_din are held stable before spi_start (min 1).
- CS_TIMEOUT, 8: cycles allowed from spi_start until spi_cs falls.
- GAP_CYC, 4: idle cycles after spi_cs rises before the next arbitration (min 1).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  level request per requester; held until its done/err pulse.
- req_mode  in  2*NREQ  mode of requester i at [2i+1:2i], {cpol,cphas}.
- req_data  in  8*NREQ  byte of requester i at [8i+7:8i].
- grant  out  NREQ  one-hot; current owner of the master.
- done  out  NREQ  one-cycle pulse; owner's transfer completed.
- err  out  NREQ  one-cycle pulse; owner's transfer timed out.
- busy  out  1  high in every state except IDLE.
- spi_start  out  1  one-cycle start pulse to the master.
- spi_mode  out  2  mode to the master; stable from SETUP through WAIT_HIGH.
- spi_din  out  8  byte to the master; same stability rule.
- spi_cs  in  1  master chip-select, active-low.

## Operation
- All outputs are registered. Reset values:
  - grant=0, done=0, err=0, busy=0, spi_start=0, spi_din=0.
  - spi_mode=0 (mode 0).
  - Round-robin pointer last=NREQ-1, so requester 0 has first priority.
- FSM states: IDLE, SETUP, LAUNCH, WAIT_LOW, WAIT_HIGH, GAP.
- IDLE:
  - If any req bit is set, select the first set bit searching last+1, last+2, … with wrap-around modulo NREQ.
  - Latch its index, req_mode and req_data into spi_mode/spi_din; set grant, busy and last to the selected index; go to SETUP.
  - If no req bit is set, stay in IDLE.
- SETUP: count SETUP_CYC cycles, then go to LAUNCH. This lets the master's sclk settle to the new cpol.
- LAUNCH: spi_start=1 for exactly one cycle; go to WAIT_LOW.
- WAIT_LOW:
  - On spi_cs==0, go to WAIT_HIGH.
  - Otherwise increment the timeout counter. When CS_TIMEOUT cycles have elapsed since LAUNCH with no low, pulse err[owner] and go to GAP.
- WAIT_HIGH: on spi_cs==1, pulse done[owner] and go to GAP. There is no timeout here; the transfer length is set by the master.
- GAP:
  - grant=0 on entry; count GAP_CYC cycles.
  - busy=0 and return to IDLE.
- Latched mode/data are never updated mid-transfer. Changes on req_mode/req_data after selection are ignored.
- A requester that drops req after being granted still runs to completion and receives done/err.
- A requester holding req after its done competes again; round-robin places it last.
- Counters are sized to ceil(log2) of the larger of SETUP_CYC, CS_TIMEOUT and GAP_CYC, plus 1. They are cleared on each state entry.

## Timing
- Arbitration latency: req seen at edge t, so grant, spi_mode and spi_din are valid after edge t.
- spi_start is asserted after edge t+SETUP_CYC and is low after edge t+SETUP_CYC+1.
- The done pulse appears in the cycle after spi_cs is first sampled high in WAIT_HIGH.
- grant falls in the same edge that done/err is deasserted. done/err and grant are never both absent while busy is high outside GAP.
- Minimum spacing between two spi_start pulses is SETUP_CYC + GAP_CYC + 3 cycles plus the transfer length.
- Simultaneous requests resolve strictly by round-robin order; no starvation. Each requester waits at most NREQ-1 transfers.
- spi_cs glitching high during WAIT_LOW is ignored. A single low sample is enough to advance.
- Asynchronous rst at any point:
  - Immediately forces the reset values; an in-flight transfer is abandoned with no done/err.
  - spi_start drops the same instant.
  - The first arbitration after reset release starts from requester 0.

## Test plan
- Single request: req=4'b0010, mode=2'b01, data=8'hA5 → grant=4'b0010 after one edge; spi_mode=01 and spi_din=A5 for 2 cycles, then one spi_start pulse. A model master drops cs 1 cycle later and raises it 34 cycles later → done[1] one-cycle pulse, then 4 GAP cycles, then busy=0.
- All four requesting continuously with modes 00/01/10/11 → grant sequence 0,1,2,3,0. The spi_mode presented at each spi_start matches the granted requester's mode.
- Timeout: model master never drops cs → err[owner] exactly 8 cycles after spi_start, no done, next requester served after the gap.
- Mid-transfer change: alter req_data[0] and deassert req[0] during WAIT_HIGH → spi_din unchanged, done[0] still pulses, requester 0 is not re-granted.
- Reset during WAIT_HIGH → all outputs 0 asynchronously, busy=0. After release with req=4'b1001, requester 0 is granted first.
- Mode stability check: assertion that spi_mode/spi_din never change between SETUP entry and done/err → passes over 1000 random requests.
